// File: rtl/csr_pkg.sv
// Shared encodings for the CSR read-modify-write sequencer: op codes, FSM states,
// read-only region marker and response ids.
package csr_pkg;
  localparam logic [1:0] CSR_OP_RD = 2'b00;
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  localparam logic [1:0] CSR_RO_REGION = 2'b11;

  localparam logic RESP_ID_PIPE = 1'b0;
  localparam logic RESP_ID_TRAP = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} csr_state_e;

  // RW always writes; RS/RC write only when the operand register is not x0
  function automatic logic csr_wr_attempt(input logic [1:0] op, input logic nowr);
    return (op == CSR_OP_RW) || ((op != CSR_OP_RD) && !nowr);
  endfunction
endpackage

// File: rtl/csr_arb_prio.sv
// Two-way arbiter: trap requester has priority, but a pipeline request held across
// STARVE_LIMIT consecutive trap grants wins the next grant.
module csr_arb_prio
  import csr_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p_valid,
  input  logic       t_valid,
  input  logic       grant_en,
  output logic [1:0] grant
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_p;

  always_comb begin
    force_p = p_valid && (cnt_q == CNT_W'(STARVE_LIMIT));
    grant   = '0;
    if (grant_en) begin
      if (t_valid && !force_p) grant[RESP_ID_TRAP] = 1'b1;
      else if (p_valid)        grant[RESP_ID_PIPE] = 1'b1;
    end
    // only trap grants that leave a pipeline request waiting advance the count
    cnt_d = cnt_q;
    if (grant[RESP_ID_PIPE] || (grant[RESP_ID_TRAP] && !p_valid)) cnt_d = '0;
    else if (grant[RESP_ID_TRAP])                                   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one CSRRW/CSRRS/CSRRC at a time onto a single-port, 1-cycle-read CSR array,
// arbitrating between the pipeline and the trap unit.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [1:0]        p_op,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              p_nowr,
  input  logic              t_valid,
  output logic              t_ready,
  input  logic [1:0]        t_op,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [DATA_W-1:0] t_wdata,
  input  logic              t_nowr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] csr_rd_addr,
  input  logic [DATA_W-1:0] csr_rd_val,
  output logic              csr_write,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_val
);
  csr_state_e        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic              nowr_q, nowr_d, id_q, id_d;
  logic              resp_valid_q, resp_valid_d, resp_id_q, resp_id_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic [1:0]        grant;
  logic              ro, wr_try, we;
  logic [DATA_W-1:0] new_val;

  csr_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_valid  (p_valid),
    .t_valid  (t_valid),
    .grant_en (state_q == S_IDLE),
    .grant    (grant)
  );

  assign p_ready = grant[RESP_ID_PIPE];
  assign t_ready = grant[RESP_ID_TRAP];

  // RMW datapath; csr_rd_val is only meaningful during WRITE
  always_comb begin
    ro     = (addr_q[ADDR_W-1 -: 2] == CSR_RO_REGION);
    wr_try = csr_wr_attempt(op_q, nowr_q);
    we     = wr_try && !ro;
    case (op_q)
      CSR_OP_RW: new_val = wdata_q;
      CSR_OP_RS: new_val = csr_rd_val | wdata_q;
      CSR_OP_RC: new_val = csr_rd_val & ~wdata_q;
      default:   new_val = csr_rd_val;
    endcase
  end

  assign csr_write   = (state_q == S_WRITE) && we;
  assign csr_wr_addr = (state_q == S_WRITE) ? addr_q  : '0;
  assign csr_wr_val  = (state_q == S_WRITE) ? new_val : '0;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    nowr_d         = nowr_q;
    id_d           = id_q;
    rd_addr_d      = rd_addr_q;
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    case (state_q)
      S_IDLE: if (grant != 2'b00) begin
        id_d      = grant[RESP_ID_TRAP];
        op_d      = id_d ? t_op    : p_op;
        addr_d    = id_d ? t_addr  : p_addr;
        wdata_d   = id_d ? t_wdata : p_wdata;
        nowr_d    = id_d ? t_nowr  : p_nowr;
        rd_addr_d = addr_d;
        state_d   = S_READ;
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        resp_rdata_d   = csr_rd_val;
        resp_illegal_d = wr_try && ro;
        resp_id_d      = id_q;
        resp_valid_d   = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= CSR_OP_RD;
      addr_q         <= '0;
      wdata_q        <= '0;
      nowr_q         <= 1'b0;
      id_q           <= RESP_ID_PIPE;
      rd_addr_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= RESP_ID_PIPE;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      nowr_q         <= nowr_d;
      id_q           <= id_d;
      rd_addr_q      <= rd_addr_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  assign csr_rd_addr  = rd_addr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;
endmodule
